output_streamer: RTL and testbench

- Drain stage directly downstream of the 32-entry Output Register.
- On a start pulse, reads a contiguous run of Output Register slots and emits each byte on a valid/ready byte stream toward external logic (UART TX, host FIFO).
- Drives the Output Register read port (index + read enable) and samples its combinational read data.
- Reports busy so the CPU control unit can hold off Output Register writes during a drain.

---
 rtl/output_pkg.sv | 21 ++
 rtl/output_streamer_if.sv | 24 ++
 rtl/output_streamer.sv | 81 ++++++++
 tb/tb_output_streamer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/output_pkg.sv
// Shared constants and state encoding for the Output Register, its drain stage and the
// control unit.
package output_pkg;

  localparam int unsigned OUT_DATA_W = 8;
  localparam int unsigned OUT_IDX_W  = 5;
  localparam int unsigned OUT_DEPTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A drain never sends more than one full pass over the register file.
  function automatic logic [OUT_IDX_W:0] clamp_count(input logic [OUT_IDX_W:0] c);
    return (c > (OUT_IDX_W + 1)'(OUT_DEPTH)) ? (OUT_IDX_W + 1)'(OUT_DEPTH) : c;
  endfunction

endpackage

// File: rtl/output_streamer_if.sv
// Output Register read port plus the outgoing valid/ready byte stream.
interface output_streamer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 5
) ();

  logic              rd_en;
  logic [IDX_W-1:0]  rd_index;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output rd_en, rd_index, tx_data, tx_valid,
    input  rd_data, tx_ready
  );

  modport slave (
    input  rd_en, rd_index, tx_data, tx_valid,
    output rd_data, tx_ready
  );

endinterface

// File: rtl/output_streamer.sv
// Drains a contiguous run of Output Register slots onto a valid/ready byte stream,
// one FETCH cycle per byte followed by a SEND cycle held until the handshake.
module output_streamer
  import output_pkg::*;
#(
  parameter int unsigned DATA_W = OUT_DATA_W,
  parameter int unsigned IDX_W  = OUT_IDX_W,
  parameter int unsigned DEPTH  = OUT_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IDX_W-1:0]   first_index,
  input  logic [IDX_W:0]     count,
  output logic               busy,
  output logic               done,
  output_streamer_if.master  bus
);

  state_e            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W:0]    remaining;
  logic [DATA_W-1:0] tx_data_q;
  logic [IDX_W:0]    count_clamped;

  assign count_clamped = (count > (IDX_W + 1)'(DEPTH)) ? (IDX_W + 1)'(DEPTH) : count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      remaining <= '0;
      tx_data_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (count_clamped != '0) begin
              idx       <= first_index;
              remaining <= count_clamped;
              state     <= ST_FETCH;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_FETCH: begin
          // Byte is captured here, so later writes to this slot cannot disturb it.
          tx_data_q <= bus.rd_data;
          state     <= ST_SEND;
        end
        ST_SEND: begin
          if (bus.tx_ready) begin
            if (remaining == (IDX_W + 1)'(1)) begin
              state <= ST_DONE;
            end else begin
              remaining <= remaining - (IDX_W + 1)'(1);
              idx       <= idx + IDX_W'(1);
              state     <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so they are glitch-free.
  assign bus.rd_en    = (state == ST_FETCH);
  assign bus.rd_index = idx;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = (state == ST_SEND);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_output_streamer.sv
// Randomised scoreboard bench for output_streamer: expected slot indices and bytes are queued
// when a drain starts and a negedge monitor checks every fetch and every stream handshake.
module tb_output_streamer;
  import output_pkg::*;

  localparam int LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] first_index;
  logic [5:0] count;
  logic       busy;
  logic       done;
  logic       tx_ready;
  logic [7:0] mem [32];

  int total = 0;
  int bad   = 0;
  int sent  = 0;
  int done_cnt = 0;

  logic [7:0] exp_data [$];
  int         exp_idx  [$];
  logic       stalled_prev = 1'b0;
  logic [7:0] prev_data;

  output_streamer_if #(.DATA_W(8), .IDX_W(5)) bus ();

  output_streamer #(.DATA_W(8), .IDX_W(5), .DEPTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .first_index (first_index),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  assign bus.rd_data  = mem[bus.rd_index];
  assign bus.tx_ready = tx_ready;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each fetch and each delivered byte against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (bus.rd_en) begin
        check("fetch expected", 32'(exp_idx.size() != 0), 1);
        if (exp_idx.size() != 0) check("rd_index", 32'(bus.rd_index), exp_idx.pop_front());
      end
      if (bus.tx_valid) begin
        if (stalled_prev) check("stall hold tx_data", 32'(bus.tx_data), 32'(prev_data));
        if (bus.tx_ready) begin
          check("byte expected", 32'(exp_data.size() != 0), 1);
          if (exp_data.size() != 0) check("tx_data", 32'(bus.tx_data), 32'(exp_data.pop_front()));
          sent++;
        end
      end else if (stalled_prev) begin
        check("tx_valid held under stall", 32'(bus.tx_valid), 1);
      end
      stalled_prev = bus.tx_valid && !bus.tx_ready;
      prev_data    = bus.tx_data;
      if (done) begin
        done_cnt++;
        check("scoreboard empty at done", 32'(exp_data.size()), 0);
      end
    end
  end

  task automatic fill_random();
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
  endtask

  // ready_mode 0: ready high except for the first 'stall' cycles; 1: random ready.
  task automatic drain(input int fi, input int cnt, input int ready_mode, input int stall,
                       input int restart_at, input bit poke);
    int n;
    int cycles;
    int first_valid;
    n = (cnt > 32) ? 32 : cnt;
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(mem[(fi + i) % 32]);
      exp_idx.push_back((fi + i) % 32);
    end
    sent        = 0;
    first_valid = 0;
    cycles      = 1;
    start       = 1'b1;
    first_index = 5'(fi);
    count       = 6'(cnt);
    tx_ready    = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : (cycles > stall);
    while (1) begin
      step();
      cycles++;
      if (bus.tx_valid && first_valid == 0) first_valid = cycles;
      if (done || cycles >= LIMIT) break;
      if (cycles == restart_at) begin
        start       = 1'b1;
        first_index = 5'($urandom);
        count       = 6'($urandom_range(1, 63));
      end else begin
        start = 1'b0;
      end
      if (poke && cycles == 4) mem[fi] = ~mem[fi];
      tx_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : (cycles > stall);
    end
    start = 1'b0;
    check("done seen", 32'(done), 1);
    check("byte count", sent, n);
    if (n > 0) check("first valid latency", first_valid, 3);
    if (ready_mode == 0 && stall == 0) check("drain cycles", cycles, 2 * n + 2);
    step();
    check("busy after done", 32'(busy), 0);
    check("done single cycle", 32'(done), 0);
    exp_data.delete();
    exp_idx.delete();
  endtask

  initial begin
    int saved_done;
    rst         = 1'b1;
    start       = 1'b0;
    first_index = '0;
    count       = '0;
    tx_ready    = 1'b0;
    fill_random();
    step();
    step();
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset tx_valid", 32'(bus.tx_valid), 0);
    check("reset rd_en", 32'(bus.rd_en), 0);
    check("reset rd_index", 32'(bus.rd_index), 0);
    check("reset tx_data", 32'(bus.tx_data), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) mem[i] = 8'hA0 + 8'(i);
    drain(0, 4, 0, 0, -1, 1'b0);

    mem[30] = 8'd11; mem[31] = 8'd22; mem[0] = 8'd33; mem[1] = 8'd44;
    drain(30, 4, 0, 0, -1, 1'b0);

    // Backpressure for five SEND cycles, with the in-flight slot overwritten meanwhile.
    fill_random();
    drain(9, 2, 0, 7, -1, 1'b1);

    drain(12, 0, 0, 0, -1, 1'b0);
    fill_random();
    drain(5, 40, 0, 0, -1, 1'b0);

    drain(20, 4, 0, 0, 4, 1'b0);

    // Reset during SEND of the second byte of four.
    fill_random();
    for (int i = 0; i < 4; i++) begin
      exp_data.push_back(mem[i]);
      exp_idx.push_back(i);
    end
    saved_done  = done_cnt;
    tx_ready    = 1'b1;
    start       = 1'b1;
    first_index = 5'd0;
    count       = 6'd4;
    step();
    start = 1'b0;
    for (int c = 2; c < 5; c++) step();
    check("second byte in SEND", 32'(bus.tx_valid), 1);
    rst = 1'b1;
    exp_data.delete();
    exp_idx.delete();
    step();
    check("rst tx_valid", 32'(bus.tx_valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst rd_en", 32'(bus.rd_en), 0);
    check("rst tx_data", 32'(bus.tx_data), 0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) step();
    check("no done after reset", done_cnt, saved_done);
    drain(7, 3, 0, 0, -1, 1'b0);

    for (int t = 0; t < 20; t++) begin
      fill_random();
      drain($urandom_range(0, 31), $urandom_range(0, 63), 1, 0, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
